// File: rtl/mtr_pkg.sv
// Shared widths, limits, channel state encoding and the speed-to-magnitude helper.
package mtr_pkg;

    localparam int DUTY_W = 11;
    localparam int SPD_W  = 12;
    localparam logic [DUTY_W-1:0] DUTY_MAX = 11'd2047;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DECEL = 2'd1,
        BRAKE = 2'd2
    } ch_state_t;

    // Absolute value of a signed speed command, clipped to the duty range
    // (-2048 would otherwise map to 2048).
    function automatic logic [DUTY_W-1:0] sat_mag(input logic [SPD_W-1:0] spd);
        logic [SPD_W-1:0] abs_val;
        abs_val = spd[SPD_W-1] ? (~spd + 12'd1) : spd;
        if (abs_val > {1'b0, DUTY_MAX}) begin
            return DUTY_MAX;
        end
        return abs_val[DUTY_W-1:0];
    endfunction

endpackage

// File: rtl/mtr_ramp_ch.sv
// One motor channel: command saturation, slew-limited duty ramp and the
// run/decelerate/brake sequence that keeps polarity from flipping under load.
module mtr_ramp_ch
    import mtr_pkg::*;
#(
    parameter int RAMP_STEP     = 16,
    parameter int BRAKE_PERIODS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              upd_tick,
    input  logic              en,
    input  logic [SPD_W-1:0]  spd,
    output logic [DUTY_W-1:0] duty,
    output logic              fwd,
    output logic              brake
);

    localparam logic [SPD_W-1:0] STEP      = SPD_W'(RAMP_STEP);
    localparam logic [3:0]       BRK_COUNT = 4'(BRAKE_PERIODS);

    ch_state_t         state_reg, state_next;
    logic [DUTY_W-1:0] duty_reg, duty_next;
    logic              fwd_reg, fwd_next;
    logic              brake_reg, brake_next;
    logic [3:0]        cnt_reg, cnt_next;

    logic [DUTY_W-1:0] mag;
    logic              tgt_dir;
    logic [SPD_W-1:0]  duty_ext;
    logic [SPD_W-1:0]  mag_ext;
    logic [SPD_W-1:0]  ramp_ext;
    logic [SPD_W-1:0]  down_ext;
    logic [DUTY_W-1:0] ramp_duty;
    logic [DUTY_W-1:0] down_duty;

    assign mag      = sat_mag(spd);
    // A zero command keeps the present direction and simply asks for duty 0.
    assign tgt_dir  = (spd == '0) ? fwd_reg : ~spd[SPD_W-1];
    assign duty_ext = {1'b0, duty_reg};
    assign mag_ext  = {1'b0, mag};

    // Candidate duties: one slew step toward the target, or one step toward zero.
    always_comb begin
        ramp_ext = mag_ext;
        if (mag_ext >= duty_ext) begin
            if ((mag_ext - duty_ext) > STEP) begin
                ramp_ext = duty_ext + STEP;
            end
        end else begin
            if ((duty_ext - mag_ext) > STEP) begin
                ramp_ext = duty_ext - STEP;
            end
        end
        down_ext = (duty_ext > STEP) ? (duty_ext - STEP) : '0;
    end

    assign ramp_duty = ramp_ext[DUTY_W-1:0];
    assign down_duty = down_ext[DUTY_W-1:0];

    // Next-state and output logic; enable overrides everything every cycle.
    always_comb begin
        state_next = state_reg;
        duty_next  = duty_reg;
        fwd_next   = fwd_reg;
        brake_next = (state_reg == BRAKE);
        cnt_next   = cnt_reg;
        if (!en) begin
            state_next = RUN;
            duty_next  = '0;
            brake_next = 1'b1;
            cnt_next   = '0;
        end else if (upd_tick) begin
            case (state_reg)
                RUN: begin
                    if (tgt_dir == fwd_reg) begin
                        duty_next = ramp_duty;
                    end else if (duty_reg == '0) begin
                        state_next = BRAKE;
                        brake_next = 1'b1;
                        cnt_next   = BRK_COUNT;
                    end else begin
                        state_next = DECEL;
                        duty_next  = down_duty;
                    end
                end
                DECEL: begin
                    if (tgt_dir == fwd_reg) begin
                        state_next = RUN;
                        duty_next  = ramp_duty;
                    end else begin
                        duty_next = down_duty;
                        if (down_duty == '0) begin
                            state_next = BRAKE;
                            brake_next = 1'b1;
                            cnt_next   = BRK_COUNT;
                        end
                    end
                end
                BRAKE: begin
                    duty_next = '0;
                    if (cnt_reg <= 4'd1) begin
                        state_next = RUN;
                        fwd_next   = tgt_dir;
                        brake_next = 1'b0;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg - 4'd1;
                    end
                end
                default: begin
                    state_next = RUN;
                end
            endcase
        end
    end

    // Channel state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= RUN;
            duty_reg  <= '0;
            fwd_reg   <= 1'b1;
            brake_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            duty_reg  <= duty_next;
            fwd_reg   <= fwd_next;
            brake_reg <= brake_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign duty  = duty_reg;
    assign fwd   = fwd_reg;
    assign brake = brake_reg;

endmodule

// File: rtl/mtr_ramp_drv.sv
// Two-channel motor command conditioner: shared update divider plus one
// ramp/brake channel per wheel.
module mtr_ramp_drv
    import mtr_pkg::*;
#(
    parameter int RAMP_STEP     = 16,
    parameter int UPDATE_DIV    = 2049,
    parameter int BRAKE_PERIODS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [SPD_W-1:0]  lft_spd,
    input  logic [SPD_W-1:0]  rght_spd,
    output logic [DUTY_W-1:0] lft_duty,
    output logic [DUTY_W-1:0] rght_duty,
    output logic              lft_fwd,
    output logic              rght_fwd,
    output logic              lft_brake,
    output logic              rght_brake,
    output logic              upd_tick
);

    localparam int CNT_W = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(UPDATE_DIV - 1);

    logic [CNT_W-1:0] div_reg, div_next;
    logic             tick_reg;

    assign div_next = (div_reg == CNT_LAST) ? '0 : div_reg + 1'b1;

    // Free-running period divider; the strobe register is high exactly while
    // the divider sits on its last count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_reg  <= '0;
            tick_reg <= 1'b0;
        end else begin
            div_reg  <= div_next;
            tick_reg <= (div_next == CNT_LAST);
        end
    end

    assign upd_tick = tick_reg;

    mtr_ramp_ch #(
        .RAMP_STEP     (RAMP_STEP),
        .BRAKE_PERIODS (BRAKE_PERIODS)
    ) u_lft (
        .clk      (clk),
        .rst_n    (rst_n),
        .upd_tick (tick_reg),
        .en       (en),
        .spd      (lft_spd),
        .duty     (lft_duty),
        .fwd      (lft_fwd),
        .brake    (lft_brake)
    );

    mtr_ramp_ch #(
        .RAMP_STEP     (RAMP_STEP),
        .BRAKE_PERIODS (BRAKE_PERIODS)
    ) u_rght (
        .clk      (clk),
        .rst_n    (rst_n),
        .upd_tick (tick_reg),
        .en       (en),
        .spd      (rght_spd),
        .duty     (rght_duty),
        .fwd      (rght_fwd),
        .brake    (rght_brake)
    );

endmodule

// File: doc/mtr_ramp_drv.md
# mtr_ramp_drv

Two-channel motor command conditioner sitting directly upstream of the per-wheel 11-bit PWM generators. Converts signed left/right speed commands into slew-limited 11-bit duty values plus direction and brake flags, updated once per PWM period. Direction reversals never flip polarity under load: the channel decelerates to zero, brakes for a fixed number of periods, then ramps up in the new direction.

## Interface
- RAMP_STEP, 16: maximum duty change per update tick (1..2047).
- UPDATE_DIV, 2049: clk cycles per update tick; matches the 2049-cycle PWM period (counter 0..2048).
- BRAKE_PERIODS, 4: update ticks brake is held between decel-to-zero and direction flip (1..15).
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  motor enable; low forces coast-to-brake immediately.
- lft_spd  in  12  signed (two's complement) left speed command.
- rght_spd  in  12  signed right speed command.
- lft_duty  out  11  left duty to PWM stage.
- rght_duty  out  11  right duty to PWM stage.
- lft_fwd  out  1  left direction, 1 = forward.
- rght_fwd  out  1  right direction.
- lft_brake  out  1  left brake request.
- rght_brake  out  1  right brake request.
- upd_tick  out  1  single-cycle strobe marking each update.

## Operation
- Shared divider counts 0..UPDATE_DIV-1, free-running (independent of en); upd_tick is high in the cycle count == UPDATE_DIV-1.
- Per channel: mag = |spd|, saturated to 2047 (−2048 → 2047). Target dir = 1 if spd > 0, 0 if spd < 0; spd == 0 keeps current dir (target mag 0).
- Channel FSM states RUN, DECEL, BRAKE; all transitions and duty changes occur only on upd_tick, except en handling.
- RUN: if target dir == fwd, duty moves toward mag by ≤ RAMP_STEP; if |mag − duty| ≤ RAMP_STEP, duty = mag exactly. If target dir ≠ fwd: duty == 0 → BRAKE (load brake count); else → DECEL and step duty down by RAMP_STEP this tick (floor 0).
- DECEL: if target dir returns to fwd → RUN and apply RUN ramp this tick. Else duty steps down by RAMP_STEP (floor 0); on reaching 0 in that tick → BRAKE with count = BRAKE_PERIODS.
- BRAKE: duty 0, brake 1; decrement count each tick; at count expiry (tick where count == 1) fwd ← target dir sampled that tick, brake 0, → RUN. Ramp-up begins next tick.
- en low: next cycle duty = 0, brake = 1, state = RUN, fwd unchanged, brake count cleared. en high again: brake drops next cycle, ramp from 0 on subsequent ticks.
- Arithmetic in 12 bits unsigned; no overflow beyond 2047 possible.

## Timing
- Reset values: all duty 0, fwd 1, brake 0, upd_tick 0, state RUN, divider 0.
- Outputs are registered; duty/fwd/brake change the cycle after upd_tick is high.
- First tick after reset: cycle UPDATE_DIV−1 (counting from first active edge after deassertion).
- Command inputs sampled only in the tick cycle (and en each cycle); changes between ticks have no effect until next tick.
- Reversal latency from duty D: ceil(D/RAMP_STEP) decel ticks + BRAKE_PERIODS ticks before ramp-up in new direction.
- Reset mid-operation: immediate return to reset values regardless of state.
- Channels fully independent; simultaneous reversal on both is legal.

## Structure
- Package mtr_pkg: DUTY_W = 11, SPD_W = 12, DUTY_MAX = 11'd2047, enum ch_state_t {RUN, DECEL, BRAKE}.
- Sub-module mtr_ramp_ch (one channel: saturation, FSM, ramp, brake counter), instantiated twice; top holds divider and upd_tick.

## Test plan
- Reset with UPDATE_DIV = 8: duty 0, fwd 1, brake 0; upd_tick every 8 cycles.
- Ramp up: lft_spd = +100, RAMP_STEP 16 → lft_duty 16,32,48,64,80,96,100 on successive ticks, then holds 100.
- Reversal: duty 64 forward, cmd −64 → 48,32,16,0, brake 1 for 4 ticks, fwd → 0, then 16,32,48,64.
- Saturation: rght_spd = −2048 from rest → ramps toward 2047, fwd 0 after brake phase; final duty exactly 2047.
- Cancelled reversal: during DECEL at duty 32, cmd returns to +80 → next tick duty 48, no brake asserted, fwd unchanged.
- en dropped mid-ramp at duty 48 → duty 0, brake 1 next cycle (no tick needed); en restored → brake 0, ramp 16,32,...
